// File: rtl/lfsr_dec_pkg.sv
// Shared constants, FSM state type and helpers for the LFSR decryption stage.
package lfsr_dec_pkg;

    localparam int unsigned NUM_TAPS = 6;

    localparam logic [5:0] TAP_TABLE [NUM_TAPS] = '{6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39};

    localparam logic [7:0] PREAMBLE_CHAR = 8'h5F;
    localparam logic [7:0] PAD_CHAR      = 8'h20;
    localparam logic [5:0] SEED_MASK     = 6'h1F;

    localparam logic [7:0] CT_BASE     = 8'd64;
    localparam logic [7:0] CT_END      = 8'd127;
    localparam logic [7:0] PT_END      = 8'd64;
    localparam int unsigned SCAN_LEN   = 8;
    localparam logic [7:0] MIN_PRE_LEN = 8'd8;
    localparam logic [7:0] PRE_LEN_MAX = 8'hFF;

    typedef enum logic [2:0] {
        START,
        LOAD,
        SCAN,
        PICK,
        DECODE,
        PAD,
        DONE
    } state_e;

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic logic [2:0] lowest_set(input logic [NUM_TAPS-1:0] m);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = NUM_TAPS - 1; i >= 0; i--) begin
            if (m[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/dat_mem.sv
// Byte-wide data memory: combinational read, synchronous write.
module dat_mem (
    input  logic       clk,
    input  logic       write_en,
    input  logic [7:0] raddr,
    input  logic [7:0] waddr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);

    logic [7:0] core [256];

    assign data_out = core[raddr];

    always_ff @(posedge clk) begin
        if (write_en) begin
            core[waddr] <= data_in;
        end
    end

endmodule

// File: rtl/lfsr6.sv
// Six-bit Fibonacci-style LFSR with loadable start state and tap pattern.
module lfsr6 (
    input  logic       clk,
    input  logic       init,
    input  logic       en,
    input  logic [5:0] taps,
    input  logic [5:0] start,
    output logic [5:0] state
);

    always_ff @(posedge clk) begin
        if (init) begin
            state <= start;
        end else if (en) begin
            state <= {state[4:0], ^(state & taps)};
        end
    end

endmodule

// File: rtl/lfsr_decrypt.sv
// Recovers LFSR start state and taps from the ciphertext preamble, then writes
// the stripped, space-padded plaintext to addresses 0..63.
module lfsr_decrypt
    import lfsr_dec_pkg::*;
(
    input  logic       clk,
    input  logic       init,
    output logic       done,
    output logic       found,
    output logic [5:0] taps_out,
    output logic [7:0] pre_len_out
);

    state_e              state_q;
    logic [5:0]          start_q;
    logic [NUM_TAPS-1:0] mask_q;
    logic [2:0]          scan_q;
    logic [2:0]          sel_q;
    logic                strip_q;
    logic [7:0]          rd_q;
    logic [7:0]          wr_q;

    logic [7:0]          raddr;
    logic [7:0]          waddr;
    logic [7:0]          data_in;
    logic [7:0]          data_out;
    logic                write_en;

    logic [5:0]          lfsr_state [NUM_TAPS];
    logic [NUM_TAPS-1:0] lfsr_en;
    logic [NUM_TAPS-1:0] hit;
    logic                lfsr_load;
    logic [5:0]          lfsr_sel;
    logic [7:0]          plain;
    logic                is_pre;

    dat_mem dm1 (
        .clk      (clk),
        .write_en (write_en),
        .raddr    (raddr),
        .waddr    (waddr),
        .data_in  (data_in),
        .data_out (data_out)
    );

    assign lfsr_load = (state_q == LOAD);

    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_lfsr
        lfsr6 u_lfsr (
            .clk   (clk),
            .init  (lfsr_load),
            .en    (lfsr_en[k]),
            .taps  (TAP_TABLE[k]),
            .start (start_q),
            .state (lfsr_state[k])
        );

        // During decode only the chosen candidate keeps stepping.
        assign lfsr_en[k] = !init && ((state_q == SCAN) ||
                                      ((state_q == DECODE) && (sel_q == 3'(k))));

        assign hit[k] = ((lfsr_state[k] ^ SEED_MASK) == data_out[5:0]) &&
                        (data_out[7:6] == 2'b01);
    end

    always_comb begin
        lfsr_sel = 6'd0;
        case (sel_q)
            3'd0:    lfsr_sel = lfsr_state[0];
            3'd1:    lfsr_sel = lfsr_state[1];
            3'd2:    lfsr_sel = lfsr_state[2];
            3'd3:    lfsr_sel = lfsr_state[3];
            3'd4:    lfsr_sel = lfsr_state[4];
            3'd5:    lfsr_sel = lfsr_state[5];
            default: lfsr_sel = 6'd0;
        endcase
    end

    assign plain  = data_out ^ {2'b00, lfsr_sel};
    assign is_pre = strip_q && (plain == PREAMBLE_CHAR);

    always_comb begin
        raddr = rd_q;
        if (state_q == START) begin
            raddr = CT_BASE;
        end else if (state_q == SCAN) begin
            raddr = CT_BASE + {5'd0, scan_q};
        end
    end

    always_comb begin
        write_en = 1'b0;
        waddr    = wr_q;
        data_in  = plain;
        if (!init) begin
            if (state_q == DECODE) begin
                write_en = !is_pre;
            end else if (state_q == PAD) begin
                write_en = (wr_q < PT_END);
                data_in  = PAD_CHAR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (init) begin
            state_q     <= START;
            start_q     <= 6'd0;
            mask_q      <= '0;
            scan_q      <= 3'd0;
            sel_q       <= 3'd0;
            strip_q     <= 1'b0;
            rd_q        <= 8'd0;
            wr_q        <= 8'd0;
            done        <= 1'b0;
            found       <= 1'b0;
            taps_out    <= 6'd0;
            pre_len_out <= 8'd0;
        end else begin
            case (state_q)
                START: begin
                    start_q <= data_out[5:0] ^ SEED_MASK;
                    state_q <= LOAD;
                end
                LOAD: begin
                    mask_q  <= '1;
                    scan_q  <= 3'd0;
                    state_q <= SCAN;
                end
                SCAN: begin
                    mask_q <= mask_q & hit;
                    scan_q <= scan_q + 3'd1;
                    if (scan_q == 3'(SCAN_LEN - 1)) begin
                        state_q <= PICK;
                    end
                end
                PICK: begin
                    if ((mask_q == '0) || (start_q == 6'd0)) begin
                        found   <= 1'b0;
                        done    <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        found       <= 1'b1;
                        sel_q       <= lowest_set(mask_q);
                        taps_out    <= TAP_TABLE[lowest_set(mask_q)];
                        pre_len_out <= MIN_PRE_LEN;
                        strip_q     <= 1'b1;
                        rd_q        <= CT_BASE + 8'(SCAN_LEN);
                        wr_q        <= 8'd0;
                        state_q     <= DECODE;
                    end
                end
                DECODE: begin
                    if (is_pre) begin
                        if (pre_len_out != PRE_LEN_MAX) begin
                            pre_len_out <= pre_len_out + 8'd1;
                        end
                    end else begin
                        strip_q <= 1'b0;
                        wr_q    <= wr_q + 8'd1;
                    end
                    rd_q <= rd_q + 8'd1;
                    if (rd_q == CT_END) begin
                        state_q <= PAD;
                    end
                end
                PAD: begin
                    if (wr_q < PT_END) begin
                        wr_q <= wr_q + 8'd1;
                    end
                    if (wr_q >= PT_END - 8'd1) begin
                        done    <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= DONE;
                end
                default: begin
                    state_q <= START;
                end
            endcase
        end
    end

endmodule
